// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory port of the load/store unit.
// slave: the unit itself; master: the pipeline and memory it talks to.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic        resp_error;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_address, req_store_data,
    input  mem_read_data,
    output req_ready, resp_valid, resp_load_data, resp_error,
    output mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_address, req_store_data,
    output mem_read_data,
    input  req_ready, resp_valid, resp_load_data, resp_error,
    input  mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word accesses on a combinational-read memory,
// sub-word load extraction, read-modify-write for byte/half stores.
module load_store_unit (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   io_bus
);
  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      r_state, w_state_next;
  logic        r_is_store, r_unsigned, r_error;
  logic [1:0]  r_size;
  logic [31:0] r_address, r_store_data, r_word;
  logic        w_illegal, w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merged;

  always_comb begin
    w_illegal = (io_bus.req_size == 2'b11) ||
                (io_bus.req_size == 2'b01 && io_bus.req_address[0]) ||
                (io_bus.req_size == 2'b10 && io_bus.req_address[1:0] != 2'b00);
    w_accept  = (r_state == StIdle) && io_bus.req_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (io_bus.req_valid) begin
          if (w_illegal)                                          w_state_next = StResp;
          else if (io_bus.req_is_store && io_bus.req_size == 2'b10) w_state_next = StWrite;
          else                                                    w_state_next = StRead;
        end
      end
      StRead:  w_state_next = r_is_store ? StWrite : StResp;
      StWrite: w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_store   <= 1'b0;
      r_unsigned   <= 1'b0;
      r_error      <= 1'b0;
      r_size       <= 2'b00;
      r_address    <= 32'h0;
      r_store_data <= 32'h0;
      r_word       <= 32'h0;
    end else begin
      if (w_accept) begin
        r_is_store   <= io_bus.req_is_store;
        r_unsigned   <= io_bus.req_unsigned;
        r_error      <= w_illegal;
        r_size       <= io_bus.req_size;
        r_address    <= io_bus.req_address;
        r_store_data <= io_bus.req_store_data;
      end
      if (r_state == StRead) r_word <= io_bus.mem_read_data;
    end
  end

  // Little-endian lanes: byte k at bits [8k+7:8k], half h at bits [16h+15:16h].
  always_comb begin
    w_byte   = r_word[{r_address[1:0], 3'b000} +: 8];
    w_half   = r_word[{r_address[1], 4'b0000} +: 16];
    w_merged = r_word;
    if (r_size == 2'b00) w_merged[{r_address[1:0], 3'b000} +: 8]  = r_store_data[7:0];
    else                 w_merged[{r_address[1], 4'b0000} +: 16] = r_store_data[15:0];
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = r_word;
    endcase
  end

  always_comb begin
    io_bus.req_ready      = 1'b0;
    io_bus.resp_valid     = 1'b0;
    io_bus.resp_error     = 1'b0;
    io_bus.resp_load_data = 32'h0;
    io_bus.mem_write      = 1'b0;
    io_bus.mem_address    = 32'h0;
    io_bus.mem_write_data = 32'h0;
    unique case (r_state)
      StIdle: io_bus.req_ready = 1'b1;
      StRead: io_bus.mem_address = {r_address[31:2], 2'b00};
      StWrite: begin
        io_bus.mem_address    = {r_address[31:2], 2'b00};
        io_bus.mem_write      = ~reset;
        io_bus.mem_write_data = (r_size == 2'b10) ? r_store_data : w_merged;
      end
      StResp: begin
        io_bus.resp_valid     = 1'b1;
        io_bus.resp_error     = r_error;
        io_bus.resp_load_data = (!r_is_store && !r_error) ? w_load : 32'h0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a word-array memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  load_store_unit_if bus ();

  load_store_unit dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign bus.mem_read_data = mem[bus.mem_address[7:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[7:2]] <= bus.mem_write_data;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_wcyc;  // 0 = no write expected
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(logic st, logic [1:0] sz, logic uns, logic [31:0] addr,
                              logic [31:0] sdata, logic [31:0] ed, logic ee, int lat,
                              int wc, logic [31:0] wa, logic [31:0] wd);
    vec_t v;
    v = '{st, sz, uns, addr, sdata, ed, ee, lat, wc, wa, wd};
    return v;
  endfunction

  task automatic set_req(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata);
    bus.req_is_store   = st;
    bus.req_size       = sz;
    bus.req_unsigned   = uns;
    bus.req_address    = addr;
    bus.req_store_data = sdata;
  endtask

  // Issues one request and observes it to completion; returns at the IDLE cycle after RESP.
  task automatic do_req(input vec_t v, input int idx);
    int lat, nwr, wcyc;
    logic [31:0] waddr, wdata, rdata;
    logic rerr;
    bit ready_seen;
    lat = 0; nwr = 0; wcyc = 0; waddr = 0; wdata = 0; rdata = 0; rerr = 0;
    ready_seen = 0;
    set_req(v.st, v.sz, v.uns, v.addr, v.sdata);
    bus.req_valid = 1'b1;
    for (int w = 0; w < 10; w++) begin
      if (bus.req_ready) begin
        ready_seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("v%0d accepted", idx), {31'h0, ready_seen}, 32'h1);
    if (!ready_seen) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (bus.mem_write) begin
        nwr++;
        wcyc  = c;
        waddr = bus.mem_address;
        wdata = bus.mem_write_data;
      end
      if (bus.resp_valid) begin
        lat   = c;
        rdata = bus.resp_load_data;
        rerr  = bus.resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d resp_error", idx), {31'h0, rerr}, {31'h0, v.exp_err});
    check($sformatf("v%0d resp_load_data", idx), rdata, v.exp_data);
    if (v.exp_wcyc == 0) begin
      check($sformatf("v%0d write count", idx), nwr, 0);
    end else begin
      check($sformatf("v%0d write count", idx), nwr, 1);
      check($sformatf("v%0d write cycle", idx), wcyc, v.exp_wcyc);
      check($sformatf("v%0d write address", idx), waddr, v.exp_waddr);
      check($sformatf("v%0d write data", idx), wdata, v.exp_wdata);
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[19];
  vec_t b2b[4];
  int   b2b_acc[4]  = '{0, 3, 6, 9};
  int   b2b_resp[4] = '{2, 5, 8, 12};

  initial begin
    int idx, nresp, nready, nwr, nrv;
    bit acc;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4'h4] = 32'h8000_7F81;  // 0x10
    mem[4'h8] = 32'h1122_3344;  // 0x20

    //           st    sz     uns   addr   sdata          data           err lat wc waddr wdata
    vecs[0]  = mk(1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFF_FF81, 0, 2, 0, 0, 0);
    vecs[1]  = mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h0000_0080, 0, 2, 0, 0, 0);
    vecs[2]  = mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF_8000, 0, 2, 0, 0, 0);
    vecs[3]  = mk(1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h0000_7F81, 0, 2, 0, 0, 0);
    vecs[4]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8000_7F81, 0, 2, 0, 0, 0);
    vecs[5]  = mk(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AB, 32'h0, 0, 3, 2, 32'h20, 32'h1122_AB44);
    vecs[6]  = mk(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'h0, 0, 3, 2, 32'h20, 32'hBEEF_AB44);
    vecs[7]  = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hBEEF_AB44, 0, 2, 0, 0, 0);
    vecs[8]  = mk(1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        32'hFFFF_FFBE, 0, 2, 0, 0, 0);
    vecs[9]  = mk(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 32'h30, 32'hDEAD_BEEF);
    vecs[10] = mk(1'b0, 2'b10, 1'b0, 32'h30, 32'h0,        32'hDEAD_BEEF, 0, 2, 0, 0, 0);
    vecs[11] = mk(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_CAFE, 32'h0, 0, 3, 2, 32'h30, 32'hCAFE_BEEF);
    vecs[12] = mk(1'b0, 2'b01, 1'b1, 32'h32, 32'h0,        32'h0000_CAFE, 0, 2, 0, 0, 0);
    vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h0,         1, 1, 0, 0, 0);
    vecs[14] = mk(1'b1, 2'b01, 1'b0, 32'h0B, 32'h1234,     32'h0,         1, 1, 0, 0, 0);
    vecs[15] = mk(1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,         1, 1, 0, 0, 0);
    vecs[16] = mk(1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        32'h0000_00AB, 0, 2, 0, 0, 0);
    vecs[17] = mk(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF12, 32'h0, 0, 3, 2, 32'h10, 32'h1200_7F81);
    vecs[18] = mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h0000_1200, 0, 2, 0, 0, 0);

    b2b[0] = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1200_7F81, 0, 0, 0, 0, 0);
    b2b[1] = mk(1'b1, 2'b10, 1'b0, 32'h30, 32'h0123_4567, 32'h0,        0, 0, 0, 0, 0);
    b2b[2] = mk(1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h0000_BEEF, 0, 0, 0, 0, 0);
    b2b[3] = mk(1'b1, 2'b00, 1'b0, 32'h30, 32'h0000_0099, 32'h0,        0, 0, 0, 0, 0);

    reset = 1'b1;
    bus.req_valid = 1'b0;
    set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("reset req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("reset resp_error", {31'h0, bus.resp_error}, 32'h0);
    check("reset resp_load_data", bus.resp_load_data, 32'h0);
    check("reset mem_write", {31'h0, bus.mem_write}, 32'h0);
    check("reset mem_address", bus.mem_address, 32'h0);
    check("reset mem_write_data", bus.mem_write_data, 32'h0);

    for (int i = 0; i < 19; i++) do_req(vecs[i], i);
    check("sw readback", mem[6'hC], 32'hCAFE_BEEF);

    // Reset in the READ cycle of a byte store: abandoned, no write, no response.
    set_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0055);
    bus.req_valid = 1'b1;
    check("rstread ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstread mem_write in reset", {31'h0, bus.mem_write}, 32'h0);
    reset = 1'b0;
    nwr = 0; nrv = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) check("rstread ready after", {31'h0, bus.req_ready}, 32'h1);
      if (bus.mem_write) nwr++;
      if (bus.resp_valid) nrv++;
    end
    check("rstread writes", nwr, 0);
    check("rstread responses", nrv, 0);
    check("rstread memory", mem[6'h8], 32'hBEEF_AB44);

    // Reset in the WRITE cycle: the strobe must be gated off immediately.
    set_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0066);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstwrite strobe before", {31'h0, bus.mem_write}, 32'h1);
    reset = 1'b1;
    #1;
    check("rstwrite strobe gated", {31'h0, bus.mem_write}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstwrite memory", mem[6'h8], 32'hBEEF_AB44);
    @(posedge clk); #1;

    // Four requests back to back with req_valid held high.
    idx = 0; nresp = 0; nready = 0;
    set_req(b2b[0].st, b2b[0].sz, b2b[0].uns, b2b[0].addr, b2b[0].sdata);
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && nresp < 4; cyc++) begin
      if (bus.resp_valid) begin
        check($sformatf("b2b resp%0d cycle", nresp), cyc, b2b_resp[nresp]);
        check($sformatf("b2b resp%0d data", nresp), bus.resp_load_data, b2b[nresp].exp_data);
        check($sformatf("b2b resp%0d error", nresp), {31'h0, bus.resp_error}, 32'h0);
        nresp++;
      end
      if (bus.req_ready) nready++;
      acc = bus.req_ready && bus.req_valid;
      if (acc) check($sformatf("b2b accept%0d cycle", idx), cyc, b2b_acc[idx]);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) set_req(b2b[idx].st, b2b[idx].sz, b2b[idx].uns, b2b[idx].addr,
                             b2b[idx].sdata);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b responses", nresp, 4);
    check("b2b accepts", idx, 4);
    check("b2b ready cycles", nready, 4);
    check("b2b memory 0x30", mem[6'hC], 32'h0123_4599);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
